// File: rtl/cic_pkg.sv
// Shared audio constants and helpers for the CIC resampler and related audio blocks.
// Contents: sample width and range limits, default CIC configuration,
// saturate16() which clamps a wide signed value to the 16-bit sample range.
package cic_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int          SAMPLE_MAX = 32767;
    localparam int          SAMPLE_MIN = -32768;

    localparam int unsigned ORDER_DEF  = 3;
    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned SHIFT_DEF  = 13;

    // Width of the value handed to saturate16; callers sign-extend into it.
    localparam int unsigned SAT_IN_W   = 64;

    // Clamp a signed value into [SAMPLE_MIN, SAMPLE_MAX].
    function automatic logic signed [SAMPLE_W-1:0] saturate16(
        input logic signed [SAT_IN_W-1:0] val
    );
        logic signed [SAMPLE_W-1:0] res;
        if (val > SAT_IN_W'(SAMPLE_MAX)) begin
            res = SAMPLE_W'(SAMPLE_MAX);
        end else if (val < SAT_IN_W'(SAMPLE_MIN)) begin
            res = SAMPLE_W'(SAMPLE_MIN);
        end else begin
            res = SAMPLE_W'(val);
        end
        return res;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: o_diff_c = i_data - previous i_data captured on en.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         output-rate strobe; loads the delay register
//   i_data     stage input (ACC_W bits, modulo arithmetic)
//   o_diff_c   combinational difference, feeds the next stage
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] i_data,
    output logic [ACC_W-1:0] o_diff_c
);

    logic [ACC_W-1:0] dly_q;
    logic [ACC_W-1:0] dly_d;

    // Delay register follows the stage input only on output-rate strobes.
    always_comb begin
        dly_d = dly_q;
        if (en) begin
            dly_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    // Wraps modulo 2^ACC_W by design.
    assign o_diff_c = i_data - dly_q;

endmodule

// File: rtl/cic_filter.sv
// CIC decimating resampler between the SID core and the I2S master.
// Integrators run on clkEn (input rate), combs run on iSample (output rate),
// so the decimation ratio tracks whatever timing the I2S master uses.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset, clears all history and oOut
//   clkEn    input-rate enable pulse
//   iSample  output-rate strobe pulse from the I2S master
//   iIn      signed 16-bit input sample
//   oOut     signed 16-bit filtered, decimated sample (registered)
// Build option: define CIC_SATURATE_EN to clamp the output to the 16-bit
// range; otherwise the low 16 bits of the shifted comb output are taken.
module cic_filter
    import cic_pkg::*;
#(
    parameter int unsigned ORDER = ORDER_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clkEn,
    input  logic                       iSample,
    input  logic signed [SAMPLE_W-1:0] iIn,
    output logic signed [SAMPLE_W-1:0] oOut
);

    logic [ACC_W-1:0] int_q [ORDER];
    logic [ACC_W-1:0] int_d [ORDER];

    // Pipelined integrator chain: each stage adds the previous stage's pre-edge value.
    always_comb begin
        for (int unsigned k = 0; k < ORDER; k++) begin
            int_d[k] = int_q[k];
        end
        if (clkEn) begin
            int_d[0] = int_q[0] + ACC_W'(iIn);
            for (int unsigned k = 1; k < ORDER; k++) begin
                int_d[k] = int_q[k] + int_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_q <= '{default: '0};
        end else begin
            int_q <= int_d;
        end
    end

    // Comb chain reads the registered last integrator, so an input enabled in
    // the same cycle as a strobe lands in the next output period.
    logic [ACC_W-1:0] comb_c [ORDER+1];

    assign comb_c[0] = int_q[ORDER-1];

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .ACC_W (ACC_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (iSample),
            .i_data   (comb_c[g]),
            .o_diff_c (comb_c[g+1])
        );
    end

    // Gain normalisation then 16-bit limiting.
    logic signed [SAMPLE_W-1:0] lim_c;

`ifdef CIC_SATURATE_EN
    assign lim_c = saturate16(SAT_IN_W'($signed(comb_c[ORDER]) >>> SHIFT));
`else
    assign lim_c = SAMPLE_W'($signed(comb_c[ORDER]) >>> SHIFT);
`endif

    logic signed [SAMPLE_W-1:0] out_q;
    logic signed [SAMPLE_W-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (iSample) begin
            out_d = lim_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign oOut = out_q;

endmodule

// File: tb/tb_cic_filter.sv
// Bench for cic_filter. Four instances share one stimulus stream:
//   u_a  ORDER=3 ACC_W=32 SHIFT=6  (unity gain at ratio 4)
//   u_s  ORDER=3 ACC_W=32 SHIFT=5  (gain 2, exercises the output limiter)
//   u_w  ORDER=3 ACC_W=24 SHIFT=6  (narrow accumulators that wrap)
//   u_o1 ORDER=1 ACC_W=32 SHIFT=0  (output is the raw sum of one period,
//        compared every strobe against a running-sum model)
module tb_cic_filter;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic i_sample;
    logic signed [15:0] i_in;
    logic signed [15:0] out_a;
    logic signed [15:0] out_s;
    logic signed [15:0] out_w;
    logic signed [15:0] out_o1;

    int total = 0;
    int bad   = 0;

    int acc_pend = 0;
    int exp_o1   = 0;

    always #5 clk = ~clk;

    cic_filter #(.ORDER(3), .ACC_W(32), .SHIFT(6)) u_a (
        .clk(clk), .rst(rst), .clkEn(clk_en), .iSample(i_sample), .iIn(i_in), .oOut(out_a));
    cic_filter #(.ORDER(3), .ACC_W(32), .SHIFT(5)) u_s (
        .clk(clk), .rst(rst), .clkEn(clk_en), .iSample(i_sample), .iIn(i_in), .oOut(out_s));
    cic_filter #(.ORDER(3), .ACC_W(24), .SHIFT(6)) u_w (
        .clk(clk), .rst(rst), .clkEn(clk_en), .iSample(i_sample), .iIn(i_in), .oOut(out_w));
    cic_filter #(.ORDER(1), .ACC_W(32), .SHIFT(0)) u_o1 (
        .clk(clk), .rst(rst), .clkEn(clk_en), .iSample(i_sample), .iIn(i_in), .oOut(out_o1));

`ifdef CIC_SATURATE_EN
    localparam int S_P20K  = 32767;
    localparam int S_N20K  = -32768;
    localparam int S_P32K  = 32767;
    localparam int S_N32K  = -32768;
`else
    localparam int S_P20K  = -25536;
    localparam int S_N20K  = 25536;
    localparam int S_P32K  = -2;
    localparam int S_N32K  = 0;
`endif

    function automatic int lim16(input int v);
`ifdef CIC_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic signed [15:0] t;
        t = 16'(v);
        return int'(t);
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock with the given strobes; the o1 model takes its strobe value
    // before this cycle's input is added (pre-edge comb read).
    task automatic tick(input logic en, input logic smp);
        clk_en   = en;
        i_sample = smp;
        if (smp) begin
            exp_o1   = lim16(acc_pend);
            acc_pend = 0;
        end
        if (en) acc_pend += int'(i_in);
        @(posedge clk);
        #1;
    endtask

    // len-1 non-strobe cycles, then one strobe cycle; checks the sum instance.
    task automatic period(input int len, input logic en_mid, input logic en_strobe);
        for (int i = 0; i < len - 1; i++) tick(en_mid, 1'b0);
        tick(en_strobe, 1'b1);
        check("o1_period_sum", int'(out_o1), exp_o1);
    endtask

    task automatic do_reset(input logic en, input logic smp);
        rst      = 1'b1;
        clk_en   = en;
        i_sample = smp;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        acc_pend = 0;
        exp_o1   = 0;
    endtask

    typedef struct {
        int x;      // input value
        int n;      // strobes to run
        int coin;   // 1: enable on strobe cycle too (period 4), 0: period 5, no enable on strobe
        int ea;
        int es;
        int ew;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    initial begin
        rst      = 1'b1;
        clk_en   = 1'b0;
        i_sample = 1'b0;
        i_in     = '0;

        tbl[0] = '{1000,   6,    1, 1000,   2000,   1000};
        tbl[1] = '{-1000,  6,    1, -1000,  -2000,  -1000};
        tbl[2] = '{1000,   6,    0, 1000,   2000,   1000};
        tbl[3] = '{-1000,  6,    0, -1000,  -2000,  -1000};
        tbl[4] = '{20000,  6,    1, 20000,  S_P20K, 20000};
        tbl[5] = '{-20000, 6,    1, -20000, S_N20K, -20000};
        tbl[6] = '{32767,  1100, 1, 32767,  S_P32K, 32767};
        tbl[7] = '{-32768, 6,    1, -32768, S_N32K, -32768};
        tbl[8] = '{0,      6,    1, 0,      0,      0};

        do_reset(1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        check("reset_a", int'(out_a), 0);
        check("reset_s", int'(out_s), 0);
        check("reset_w", int'(out_w), 0);
        check("reset_o1", int'(out_o1), 0);

        // Steady-state gain across input levels, limiter and wrap cases.
        for (int v = 0; v < NV; v++) begin
            i_in = 16'(tbl[v].x);
            for (int s = 0; s < tbl[v].n; s++) begin
                if (tbl[v].coin != 0) period(4, 1'b1, 1'b1);
                else                  period(5, 1'b1, 1'b0);
            end
            check($sformatf("vec%0d_a", v), int'(out_a), tbl[v].ea);
            check($sformatf("vec%0d_s", v), int'(out_s), tbl[v].es);
            check($sformatf("vec%0d_w", v), int'(out_w), tbl[v].ew);
        end

        // Hold and decay: last settled strobe has no enable, then enables stop.
        i_in = 16'sd1000;
        for (int s = 0; s < 6; s++) period(4, 1'b1, 1'b1);
        period(4, 1'b1, 1'b0);
        check("pre_decay_a", int'(out_a), 1000);
        for (int s = 0; s < 3; s++) period(4, 1'b0, 1'b0);
        check("decay_a", int'(out_a), 0);
        check("decay_s", int'(out_s), 0);
        check("decay_w", int'(out_w), 0);
        for (int s = 0; s < 3; s++) begin
            period(4, 1'b0, 1'b0);
            check($sformatf("decay_hold%0d_a", s), int'(out_a), 0);
        end

        // Reset mid-operation with both strobes high.
        for (int s = 0; s < 6; s++) period(4, 1'b1, 1'b1);
        check("pre_reset_a", int'(out_a), 1000);
        do_reset(1'b1, 1'b1);
        check("mid_reset_a", int'(out_a), 0);
        check("mid_reset_s", int'(out_s), 0);
        check("mid_reset_w", int'(out_w), 0);
        check("mid_reset_o1", int'(out_o1), 0);
        for (int s = 0; s < 4; s++) period(4, 1'b1, 1'b1);
        check("post_reset_a", int'(out_a), 1000);
        check("post_reset_s", int'(out_s), 2000);
        check("post_reset_w", int'(out_w), 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
